genius_sequencer: RTL and testbench

- Parametrised game engine for the Genius (Simon) memory game: one clock domain.
- Merges the round controller and sequence datapath into one block.
- Generates a pseudo-random colour sequence and plays it back on one-hot lamps, then checks the player's button presses against it.
- Generalises the fixed 4-colour game to N colours, configurable maximum length, display timing and reply timeout; adds level/score reporting.

---
 rtl/genius_pkg.sv | 32 +++
 rtl/genius_lfsr.sv | 33 +++
 rtl/genius_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_genius_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | genius_pkg                                                           |
// | Shared types and helpers for the Genius (Simon) game engine.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package genius_pkg;

    localparam int          c_max_colors = 8;
    // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
    localparam logic [15:0] c_lfsr_taps  = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADD      = 3'd1,
        ST_SHOW_ON  = 3'd2,
        ST_SHOW_OFF = 3'd3,
        ST_USER     = 3'd4,
        ST_WIN      = 3'd5,
        ST_LOSE     = 3'd6
    } state_t;

    function automatic logic [c_max_colors-1:0] onehot_decode(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

    function automatic logic onehot_valid(input logic [c_max_colors-1:0] vec);
        return (vec != 8'd0) && ((vec & (vec - 8'd1)) == 8'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/genius_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | genius_lfsr                                                          |
// | Free-running 16-bit maximal Fibonacci LFSR, low byte exported.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module genius_lfsr
    import genius_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] o_low_byte
);

    logic [15:0] r_lfsr;
    logic        w_feedback;

    assign w_feedback = ^(r_lfsr & c_lfsr_taps);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_feedback};
        end
    end

    assign o_low_byte = r_lfsr[7:0];

endmodule
`default_nettype wire

// File: rtl/genius_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | genius_sequencer                                                     |
// | Simon-style game engine: grows a random colour sequence, plays it    |
// | on one-hot lamps and checks the player's presses against it.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module genius_sequencer
    import genius_pkg::*;
#(
    parameter int          N_COLORS       = 4,
    parameter int          MAX_LEN        = 16,
    parameter int          SHOW_CYCLES    = 25000000,
    parameter int          GAP_CYCLES     = 12500000,
    parameter int          TIMEOUT_CYCLES = 150000000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                             CLOCK,
    input  logic                             reset,
    input  logic                             enter,
    input  logic [N_COLORS-1:0]              btn,
    output logic [N_COLORS-1:0]              leds,
    output logic [$clog2(MAX_LEN+1)-1:0]     level,
    output logic                             user_turn,
    output logic                             win,
    output logic                             lose
);

    localparam int c_cw   = $clog2(N_COLORS);
    localparam int c_lw   = $clog2(MAX_LEN + 1);
    localparam int c_aw   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int c_tmax = (TIMEOUT_CYCLES > SHOW_CYCLES)
                          ? ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES)
                          : ((SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES);
    localparam int c_tw   = $clog2(c_tmax + 1);

    localparam logic [c_tw-1:0] c_show_last    = c_tw'(SHOW_CYCLES - 1);
    localparam logic [c_tw-1:0] c_gap_last     = c_tw'(GAP_CYCLES - 1);
    localparam logic [c_tw-1:0] c_timeout_last = c_tw'(TIMEOUT_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [c_lw-1:0]     r_level;
    logic [c_lw-1:0]     r_play_idx;
    logic [c_lw-1:0]     r_check_idx;
    logic [c_tw-1:0]     r_timer;
    logic [c_cw-1:0]     r_ram [MAX_LEN];

    logic [7:0]          w_rand;
    logic [c_cw-1:0]     w_new_color;
    logic [N_COLORS-1:0] w_play_1h;
    logic [N_COLORS-1:0] w_expect_1h;
    logic                w_show_done;
    logic                w_gap_done;
    logic                w_timeout;
    logic                w_btn_none;
    logic                w_press_ok;
    logic                w_last;

    logic [N_COLORS-1:0] r_leds;
    logic                r_user_turn;
    logic                r_win;
    logic                r_lose;
    logic [N_COLORS-1:0] w_leds_next;
    logic                w_user_turn_next;
    logic                w_win_next;
    logic                w_lose_next;

    genius_lfsr #(
        .SEED       (LFSR_SEED)
    ) u_lfsr (
        .clk        (CLOCK),
        .rst        (reset),
        .o_low_byte (w_rand)
    );

    assign w_new_color = c_cw'(w_rand % 8'(N_COLORS));
    assign w_play_1h   = N_COLORS'(onehot_decode(3'(r_ram[r_play_idx[c_aw-1:0]])));
    assign w_expect_1h = N_COLORS'(onehot_decode(3'(r_ram[r_check_idx[c_aw-1:0]])));

    assign w_show_done = (r_timer == c_show_last);
    assign w_gap_done  = (r_timer == c_gap_last);
    assign w_timeout   = (r_timer == c_timeout_last);
    assign w_btn_none  = (btn == '0);
    assign w_press_ok  = onehot_valid(8'(btn)) && (btn == w_expect_1h);
    assign w_last      = (r_check_idx == (r_level - c_lw'(1)));

    // State register plus registered outputs (decoded from the next state
    // so they line up with the state they describe)
    always_ff @(posedge CLOCK) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_leds      <= '0;
            r_user_turn <= 1'b0;
            r_win       <= 1'b0;
            r_lose      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_leds      <= w_leds_next;
            r_user_turn <= w_user_turn_next;
            r_win       <= w_win_next;
            r_lose      <= w_lose_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (enter) w_state_next = ST_ADD;
            end
            ST_ADD: begin
                w_state_next = ST_SHOW_OFF;
            end
            ST_SHOW_OFF: begin
                if (w_gap_done) begin
                    w_state_next = (r_play_idx < r_level) ? ST_SHOW_ON : ST_USER;
                end
            end
            ST_SHOW_ON: begin
                if (w_show_done) w_state_next = ST_SHOW_OFF;
            end
            ST_USER: begin
                if (w_btn_none) begin
                    if (w_timeout) w_state_next = ST_LOSE;
                end else if (w_press_ok) begin
                    if (w_last) begin
                        w_state_next = (r_level == c_lw'(MAX_LEN)) ? ST_WIN : ST_ADD;
                    end
                end else begin
                    w_state_next = ST_LOSE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_leds_next      = '0;
        w_user_turn_next = 1'b0;
        w_win_next       = 1'b0;
        w_lose_next      = 1'b0;
        case (w_state_next)
            ST_SHOW_ON: w_leds_next      = w_play_1h;
            ST_USER:    w_user_turn_next = 1'b1;
            ST_WIN:     w_win_next       = 1'b1;
            ST_LOSE:    w_lose_next      = 1'b1;
            default:    ;
        endcase
    end

    // Sequence datapath: level, playback/check indices and the shared timer
    always_ff @(posedge CLOCK) begin
        if (reset) begin
            r_level     <= '0;
            r_play_idx  <= '0;
            r_check_idx <= '0;
            r_timer     <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (enter) begin
                        r_level <= '0;
                        r_timer <= '0;
                    end
                end
                ST_ADD: begin
                    r_level    <= r_level + c_lw'(1);
                    r_play_idx <= '0;
                    r_timer    <= '0;
                end
                ST_SHOW_OFF: begin
                    if (w_gap_done) begin
                        r_timer     <= '0;
                        r_check_idx <= '0;
                    end else begin
                        r_timer <= r_timer + c_tw'(1);
                    end
                end
                ST_SHOW_ON: begin
                    if (w_show_done) begin
                        r_timer    <= '0;
                        r_play_idx <= r_play_idx + c_lw'(1);
                    end else begin
                        r_timer <= r_timer + c_tw'(1);
                    end
                end
                ST_USER: begin
                    if (w_btn_none) begin
                        r_timer <= r_timer + c_tw'(1);
                    end else if (w_press_ok) begin
                        r_timer     <= '0;
                        r_check_idx <= r_check_idx + c_lw'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (r_state == ST_ADD) begin
            r_ram[r_level[c_aw-1:0]] <= w_new_color;
        end
    end

    // Lamps echo the buttons combinationally while the player is answering
    assign leds      = (r_state == ST_USER) ? btn : r_leds;
    assign level     = r_level;
    assign user_turn = r_user_turn;
    assign win       = r_win;
    assign lose      = r_lose;

endmodule
`default_nettype wire

// File: tb/tb_genius_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_genius_sequencer                                                  |
// | Scoreboard bench: driver queues expected events, monitor checks them.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_genius_sequencer;

    localparam int c_show = 4;
    localparam int c_gap  = 2;
    localparam int c_max  = 3;
    localparam int K_NONE = 0;
    localparam int K_LAMP = 1;
    localparam int K_TURN = 2;
    localparam int K_END  = 3;

    typedef struct {
        int kind;
        int a;
        int b;
        int c;
    } ev_t;

    logic       CLOCK;
    logic       reset;
    logic       enter;
    logic [3:0] btn;
    logic [3:0] leds;
    logic [1:0] level;
    logic       user_turn;
    logic       win;
    logic       lose;

    int         n_checks = 0;
    int         n_fail   = 0;
    ev_t        exp_q[$];
    logic [3:0] seen[$];

    genius_sequencer #(
        .N_COLORS       (4),
        .MAX_LEN        (c_max),
        .SHOW_CYCLES    (c_show),
        .GAP_CYCLES     (c_gap),
        .TIMEOUT_CYCLES (10),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .CLOCK     (CLOCK),
        .reset     (reset),
        .enter     (enter),
        .btn       (btn),
        .leds      (leds),
        .level     (level),
        .user_turn (user_turn),
        .win       (win),
        .lose      (lose)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push_ev(input int kind, input int a, input int b, input int c);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        e.c    = c;
        exp_q.push_back(e);
    endtask

    function automatic ev_t pop_ev();
        ev_t e;
        e.kind = K_NONE;
        e.a    = -1;
        e.b    = -1;
        e.c    = -1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        return e;
    endfunction

    // Monitor: turns DUT output activity into events and scores them
    initial begin
        int         m_dark = 0;
        int         m_len  = 0;
        int         m_gap  = 0;
        bit         m_lit  = 1'b0;
        bit         m_bad  = 1'b0;
        logic [3:0] m_col  = 4'd0;
        logic [1:0] m_lv   = 2'd0;
        bit         m_u    = 1'b0;
        bit         m_w    = 1'b0;
        bit         m_l    = 1'b0;
        ev_t        e;
        forever begin
            @(negedge CLOCK);
            if (reset) begin
                m_lit  = 1'b0;
                m_dark = 0;
                m_lv   = 2'd0;
                m_u    = 1'b0;
                m_w    = 1'b0;
                m_l    = 1'b0;
            end else begin
                if (level != m_lv) m_dark = 0;
                if (user_turn) begin
                    if (!m_u) begin
                        e = pop_ev();
                        chk("event_kind_turn", K_TURN, e.kind);
                        chk("turn_gap", m_dark, e.a);
                        chk("turn_level_mon", int'(level), e.b);
                    end
                end else if (leds != 4'd0) begin
                    if (!m_lit) begin
                        m_lit = 1'b1;
                        m_len = 1;
                        m_gap = m_dark;
                        m_col = leds;
                        m_bad = !$onehot(leds);
                        seen.push_back(leds);
                    end else begin
                        m_len++;
                        if (leds != m_col) m_bad = 1'b1;
                    end
                end else begin
                    if (m_lit) begin
                        e = pop_ev();
                        chk("event_kind_lamp", K_LAMP, e.kind);
                        chk("lamp_len", m_len, e.a);
                        chk("lamp_gap", m_gap, e.b);
                        chk("lamp_onehot_stable", int'(m_bad), 0);
                        m_lit  = 1'b0;
                        m_dark = 0;
                    end
                    m_dark++;
                end
                if ((win && !m_w) || (lose && !m_l)) begin
                    e = pop_ev();
                    chk("event_kind_end", K_END, e.kind);
                    chk("end_win", int'(win), e.a);
                    chk("end_lose", int'(lose), e.b);
                    chk("end_level", int'(level), e.c);
                end
                m_u  = user_turn;
                m_w  = win;
                m_l  = lose;
                m_lv = level;
            end
        end
    end

    task automatic step();
        @(posedge CLOCK);
        #2;
    endtask

    task automatic pulse_enter();
        enter = 1'b1;
        step();
        enter = 1'b0;
    endtask

    task automatic press(input logic [3:0] b);
        btn = b;
        #1;
        chk("leds_echo", int'(leds), int'(b));
        step();
        btn = 4'd0;
    endtask

    // Queue the playback of round r and wait for the player's turn
    task automatic round_start(input int r, input bit noisy);
        bit ok;
        for (int i = 0; i < r; i++) push_ev(K_LAMP, c_show, c_gap, 0);
        push_ev(K_TURN, c_gap, r, 0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (user_turn) begin
                ok = 1'b1;
                break;
            end
            btn = (noisy && (i % 3 == 1)) ? 4'b0100 : 4'b0000;
            step();
        end
        btn = 4'd0;
        chk("turn_reached", int'(ok), 1);
        chk("seen_count", seen.size(), r);
        chk("turn_level", int'(level), r);
    endtask

    task automatic replay(input int r);
        for (int i = 0; i < r; i++) begin
            press((i < seen.size()) ? seen[i] : 4'b0001);
        end
        seen.delete();
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, int'({leds, level, user_turn, win, lose}), 0);
    endtask

    initial begin
        logic [3:0] wrong;
        bit         found;
        reset = 1'b1;
        enter = 1'b0;
        btn   = 4'd0;

        // reset and idle
        step();
        chk_all_zero("reset_outputs");
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all_zero("idle_outputs");
        end

        // full win
        pulse_enter();
        chk("add_level", int'(level), 0);
        for (int r = 1; r <= c_max; r++) begin
            round_start(r, 1'b0);
            if (r == c_max) push_ev(K_END, 1, 0, c_max);
            replay(r);
        end
        chk("win_flag", int'(win), 1);
        chk("win_level", int'(level), c_max);
        chk("win_user_turn", int'(user_turn), 0);
        btn = 4'b0001;
        step();
        btn = 4'd0;
        step();
        chk("win_held", int'({win, lose, level}), 'b10_11);

        // wrong colour
        pulse_enter();
        chk("newgame_level", int'(level), 0);
        round_start(1, 1'b0);
        wrong = (seen.size() > 0) ? {seen[0][2:0], seen[0][3]} : 4'b0001;
        seen.delete();
        push_ev(K_END, 0, 1, 1);
        press(wrong);
        chk("wrong_lose", int'({lose, level, user_turn}), 'b1_01_0);

        // restart from LOSE, then multi-bit press
        pulse_enter();
        step();
        chk("restart_level", int'(level), 1);
        chk("restart_lose_clear", int'(lose), 0);
        round_start(1, 1'b0);
        seen.delete();
        push_ev(K_END, 0, 1, 1);
        press(4'b0011);
        chk("multi_lose", int'(lose), 1);

        // timeout at exactly the tenth idle cycle
        pulse_enter();
        round_start(1, 1'b0);
        seen.delete();
        push_ev(K_END, 0, 1, 1);
        repeat (9) step();
        chk("pre_timeout", int'({lose, user_turn}), 'b01);
        step();
        chk("timeout_lose", int'({lose, user_turn}), 'b10);

        // nine idle cycles then a correct press survives
        pulse_enter();
        round_start(1, 1'b0);
        repeat (9) step();
        replay(1);
        chk("late_press_ok", int'({lose, user_turn}), 0);

        // ignored btn during playback and ignored enter during the turn
        round_start(2, 1'b1);
        enter = 1'b1;
        step();
        enter = 1'b0;
        chk("enter_ignored", int'({user_turn, level}), 'b1_10);
        replay(2);

        // reset in the middle of a lamp
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (leds != 4'd0 && !user_turn) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("lamp_before_reset", int'(found), 1);
        reset = 1'b1;
        exp_q.delete();
        seen.delete();
        step();
        chk_all_zero("midgame_reset");
        reset = 1'b0;
        repeat (12) step();
        chk_all_zero("post_reset_idle");

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
